// File: rtl/rsp_s2_prep_phase_gen_nlane.sv
// ---------------------------------------------------------------------------
// rsp_s2_prep_phase_gen_nlane
//
// Multi-lane phase generator. A table of {base,step} entries is loaded
// sequentially after reset. A start request selects one entry. The block then
// runs each lane k as a phase accumulator seeded with base + k*step. Every
// accepted data beat emits all lane phases one cycle later and advances each
// lane by step*LANES (full mode) or step*LANES/2 (half mode). All phase
// arithmetic wraps modulo 2^PHASE_W.
//
// Optional feature macro: PG_TABLE_READBACK_EN
//   defined   : i_cfg_ren/i_cfg_raddr read table entries back on
//               o_cfg_rdata/o_cfg_rvalid two cycles after the request.
//               The FSM's own table read takes priority over a readback.
//   undefined : readback inputs are ignored and the readback outputs are 0.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   i_cfg_wen/wdata : table write strobe and {base,step} data
//   i_cfg_ren/raddr : readback request and entry address
//   o_cfg_rdata/rvalid : readback data and valid
//   i_start, i_entry_sel, i_mode_half : frame start, entry select, half mode
//   i_data_valid, i_data_last : data beat strobe and end-of-frame marker
//   o_phase         : lane k phase at bits [k*PHASE_W +: PHASE_W]
//   o_valid, o_last : output beat valid and last
//   o_ready         : high while the generator is running a frame
//   o_tbl_full      : table fully loaded
//   o_err           : sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module rsp_s2_prep_phase_gen_nlane #(
  parameter int LANES     = 4,
  parameter int PHASE_W   = 16,
  parameter int ENTRY_NUM = 32,
  localparam int ENTRY_AW = $clog2(ENTRY_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cfg_wen,
  input  logic [2*PHASE_W-1:0]       i_cfg_wdata,
  input  logic                       i_cfg_ren,
  input  logic [ENTRY_AW-1:0]        i_cfg_raddr,
  output logic [2*PHASE_W-1:0]       o_cfg_rdata,
  output logic                       o_cfg_rvalid,
  input  logic                       i_start,
  input  logic [ENTRY_AW-1:0]        i_entry_sel,
  input  logic                       i_mode_half,
  input  logic                       i_data_valid,
  input  logic                       i_data_last,
  output logic [LANES*PHASE_W-1:0]   o_phase,
  output logic                       o_valid,
  output logic                       o_last,
  output logic                       o_ready,
  output logic                       o_tbl_full,
  output logic                       o_err
);

  localparam int LG_LANES = $clog2(LANES);
  localparam int PTR_W    = ENTRY_AW + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRY_NUM - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_ARM  = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [1:0]               state_r;
  logic [1:0]               state_nxt_s;
  logic [PTR_W-1:0]         wptr_r;
  logic                     full_r;
  logic                     err_r;
  logic                     err_set_s;
  logic                     cfg_wr_ok_s;
  logic                     start_ok_s;
  logic [ENTRY_AW-1:0]      sel_r;
  logic                     mode_half_r;
  logic [2*PHASE_W-1:0]     entry_r;
  logic [PHASE_W-1:0]       base_s;
  logic [PHASE_W-1:0]       step_s;
  logic [PHASE_W-1:0]       lane_r [LANES];
  logic [PHASE_W-1:0]       inc_r;
  logic [LANES*PHASE_W-1:0] phase_r;
  logic                     valid_r;
  logic                     last_r;
  logic                     ready_r;
  logic [2*PHASE_W-1:0]     tbl_r [ENTRY_NUM];

  assign base_s      = entry_r[2*PHASE_W-1:PHASE_W];
  assign step_s      = entry_r[PHASE_W-1:0];
  // Table loading is only legal in IDLE and only until the table is full.
  assign cfg_wr_ok_s = (state_r == ST_IDLE) && i_cfg_wen && !full_r;
  assign start_ok_s  = (state_r == ST_IDLE) && i_start && full_r;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_RD;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RD:  state_nxt_s = ST_ARM;
      ST_ARM: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (i_data_valid && i_data_last) state_nxt_s = ST_IDLE;
        else                             state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Error sources: writes outside IDLE or past a full table, start before full.
  always_comb begin
    err_set_s = 1'b0;
    if (i_cfg_wen && ((state_r != ST_IDLE) || full_r)) begin
      err_set_s = 1'b1;
    end else if ((state_r == ST_IDLE) && i_start && !full_r) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sequencer state, write pointer, status flags and frame parameter capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b0;
      wptr_r      <= {PTR_W{1'b0}};
      full_r      <= 1'b0;
      err_r       <= 1'b0;
      sel_r       <= {ENTRY_AW{1'b0}};
      mode_half_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Ready tracks the state register exactly, but as its own flop.
      ready_r <= (state_nxt_s == ST_RUN);
      if (err_set_s) err_r <= 1'b1;
      if (cfg_wr_ok_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
        full_r <= (wptr_r == PTR_LAST);
      end
      if (start_ok_s) begin
        sel_r       <= i_entry_sel;
        mode_half_r <= i_mode_half;
      end
    end
  end

  // Entry table storage; contents are not reset and must be reloaded.
  always_ff @(posedge clk) begin
    if (!rst && cfg_wr_ok_s) begin
      tbl_r[wptr_r[ENTRY_AW-1:0]] <= i_cfg_wdata;
    end
  end

  // Phase datapath: entry fetch, lane seeding and per-beat accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_r <= {(2*PHASE_W){1'b0}};
      inc_r   <= {PHASE_W{1'b0}};
      phase_r <= {(LANES*PHASE_W){1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      for (int k = 0; k < LANES; k++) lane_r[k] <= {PHASE_W{1'b0}};
    end else begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      case (state_r)
        ST_RD: entry_r <= tbl_r[sel_r];
        ST_ARM: begin
          for (int k = 0; k < LANES; k++) begin
            lane_r[k] <= base_s + step_s * PHASE_W'(k);
          end
          // LANES is a power of two, so the increment is a plain shift.
          inc_r <= mode_half_r ? (step_s << (LG_LANES - 1)) : (step_s << LG_LANES);
        end
        ST_RUN: begin
          if (i_data_valid) begin
            for (int k = 0; k < LANES; k++) begin
              phase_r[k*PHASE_W +: PHASE_W] <= lane_r[k];
              lane_r[k]                     <= lane_r[k] + inc_r;
            end
            valid_r <= 1'b1;
            last_r  <= i_data_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PG_TABLE_READBACK_EN
  // Two-slot request queue: slot req feeds the read, skid absorbs one request
  // that arrives while the FSM owns the table read in RD.
  logic                 rb_req_r;
  logic [ENTRY_AW-1:0]  rb_addr_r;
  logic                 rb_skid_v_r;
  logic [ENTRY_AW-1:0]  rb_skid_addr_r;
  logic [2*PHASE_W-1:0] rb_rdata_r;
  logic                 rb_rvalid_r;
  logic                 rb_busy_s;

  assign rb_busy_s = (state_r == ST_RD);

  // Readback request pipeline and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_req_r       <= 1'b0;
      rb_addr_r      <= {ENTRY_AW{1'b0}};
      rb_skid_v_r    <= 1'b0;
      rb_skid_addr_r <= {ENTRY_AW{1'b0}};
      rb_rdata_r     <= {(2*PHASE_W){1'b0}};
      rb_rvalid_r    <= 1'b0;
    end else begin
      rb_rvalid_r <= 1'b0;
      if (rb_busy_s) begin
        // Pending read is held. A new request fills the first free slot;
        // with both slots occupied it is dropped.
        if (i_cfg_ren) begin
          if (!rb_req_r) begin
            rb_req_r  <= 1'b1;
            rb_addr_r <= i_cfg_raddr;
          end else if (!rb_skid_v_r) begin
            rb_skid_v_r    <= 1'b1;
            rb_skid_addr_r <= i_cfg_raddr;
          end
        end
      end else begin
        if (rb_req_r) begin
          rb_rdata_r  <= tbl_r[rb_addr_r];
          rb_rvalid_r <= 1'b1;
        end
        if (rb_skid_v_r) begin
          rb_req_r       <= 1'b1;
          rb_addr_r      <= rb_skid_addr_r;
          rb_skid_v_r    <= i_cfg_ren;
          rb_skid_addr_r <= i_cfg_raddr;
        end else begin
          rb_req_r  <= i_cfg_ren;
          rb_addr_r <= i_cfg_raddr;
        end
      end
    end
  end

  assign o_cfg_rdata  = rb_rdata_r;
  assign o_cfg_rvalid = rb_rvalid_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{i_cfg_ren, i_cfg_raddr};
  assign o_cfg_rdata  = {(2*PHASE_W){1'b0}};
  assign o_cfg_rvalid = 1'b0;
`endif

  assign o_phase    = phase_r;
  assign o_valid    = valid_r;
  assign o_last     = last_r;
  assign o_ready    = ready_r;
  assign o_tbl_full = full_r;
  assign o_err      = err_r;

endmodule

// File: tb/tb_rsp_s2_prep_phase_gen_nlane.sv
module tb_rsp_s2_prep_phase_gen_nlane;
  localparam int LANES     = 4;
  localparam int PHASE_W   = 16;
  localparam int ENTRY_NUM = 32;
  localparam int ENTRY_AW  = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_cfg_wen;
  logic [2*PHASE_W-1:0]     i_cfg_wdata;
  logic                     i_cfg_ren;
  logic [ENTRY_AW-1:0]      i_cfg_raddr;
  logic [2*PHASE_W-1:0]     o_cfg_rdata;
  logic                     o_cfg_rvalid;
  logic                     i_start;
  logic [ENTRY_AW-1:0]      i_entry_sel;
  logic                     i_mode_half;
  logic                     i_data_valid;
  logic                     i_data_last;
  logic [LANES*PHASE_W-1:0] o_phase;
  logic                     o_valid;
  logic                     o_last;
  logic                     o_ready;
  logic                     o_tbl_full;
  logic                     o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rsp_s2_prep_phase_gen_nlane #(
    .LANES(LANES), .PHASE_W(PHASE_W), .ENTRY_NUM(ENTRY_NUM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cfg_wen(i_cfg_wen), .i_cfg_wdata(i_cfg_wdata),
    .i_cfg_ren(i_cfg_ren), .i_cfg_raddr(i_cfg_raddr),
    .o_cfg_rdata(o_cfg_rdata), .o_cfg_rvalid(o_cfg_rvalid),
    .i_start(i_start), .i_entry_sel(i_entry_sel), .i_mode_half(i_mode_half),
    .i_data_valid(i_data_valid), .i_data_last(i_data_last),
    .o_phase(o_phase), .o_valid(o_valid), .o_last(o_last),
    .o_ready(o_ready), .o_tbl_full(o_tbl_full), .o_err(o_err)
  );

  // Table contents used throughout: entry 5 and 7 are the directed vectors.
  function automatic logic [31:0] entry_val(input int i);
    if (i == 5)      return {16'h0100, 16'h0010};
    else if (i == 7) return {16'hFFF0, 16'h0008};
    else             return {16'(16'h1000 + i), 16'(i + 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_cfg_wen = 1'b0; i_cfg_wdata = 32'h0; i_cfg_ren = 1'b0; i_cfg_raddr = 5'd0;
    i_start = 1'b0; i_entry_sel = 5'd0; i_mode_half = 1'b0;
    i_data_valid = 1'b0; i_data_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      i_cfg_wen = 1'b1;
      i_cfg_wdata = entry_val(i);
      tick();
    end
    i_cfg_wen = 1'b0;
  endtask

  task automatic start_frame(input logic [4:0] sel, input logic mode);
    i_start = 1'b1; i_entry_sel = sel; i_mode_half = mode;
    tick();
    i_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic beat(input logic last);
    i_data_valid = 1'b1; i_data_last = last;
    tick();
    i_data_valid = 1'b0; i_data_last = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h want 0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", o_valid); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0h want 0", o_last); end
    checks++; if (o_phase !== 64'h0) begin errors++; $display("FAIL reset_phase: got %h want 0", o_phase); end
    checks++; if (o_tbl_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", o_tbl_full); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h want 0", o_err); end
    checks++; if (o_cfg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0h want 0", o_cfg_rvalid); end
    checks++; if (o_cfg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", o_cfg_rdata); end
  endtask

  task automatic test_load();
    load_range(0, 30);
    checks++; if (o_tbl_full !== 1'b0) begin errors++; $display("FAIL load31_full: got %0h want 0", o_tbl_full); end
    load_range(31, 31);
    checks++; if (o_tbl_full !== 1'b1) begin errors++; $display("FAIL load32_full: got %0h want 1", o_tbl_full); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL load32_err: got %0h want 0", o_err); end
  endtask

  task automatic test_mode0();
    start_frame(5'd5, 1'b0);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL m0_ready: got %0h want 1", o_ready); end
    beat(1'b0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL m0_b0_valid: got %0h want 1", o_valid); end
    checks++; if (o_phase !== 64'h0130_0120_0110_0100) begin errors++; $display("FAIL m0_b0_phase: got %h want 0130012001100100", o_phase); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL m0_b0_last: got %0h want 0", o_last); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL m0_gap_valid: got %0h want 0", o_valid); end
    checks++; if (o_phase !== 64'h0130_0120_0110_0100) begin errors++; $display("FAIL m0_gap_hold: got %h want 0130012001100100", o_phase); end
    beat(1'b1);
    checks++; if (o_phase !== 64'h0170_0160_0150_0140) begin errors++; $display("FAIL m0_b1_phase: got %h want 0170016001500140", o_phase); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL m0_b1_last: got %0h want 1", o_last); end
    tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL m0_end_ready: got %0h want 0", o_ready); end
  endtask

  task automatic test_mode1();
    start_frame(5'd5, 1'b1);
    beat(1'b0);
    checks++; if (o_phase !== 64'h0130_0120_0110_0100) begin errors++; $display("FAIL m1_b0_phase: got %h want 0130012001100100", o_phase); end
    beat(1'b1);
    checks++; if (o_phase !== 64'h0150_0140_0130_0120) begin errors++; $display("FAIL m1_b1_phase: got %h want 0150014001300120", o_phase); end
    tick();
  endtask

  task automatic test_wrap();
    start_frame(5'd7, 1'b0);
    beat(1'b1);
    checks++; if (o_phase !== 64'h0008_0000_FFF8_FFF0) begin errors++; $display("FAIL wrap_phase: got %h want 00080000fff8fff0", o_phase); end
    tick();
  endtask

  task automatic test_last3();
    start_frame(5'd5, 1'b0);
    // A start while running must be ignored.
    i_start = 1'b1; i_entry_sel = 5'd7;
    beat(1'b0);
    i_start = 1'b0;
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL l3_b0_last: got %0h want 0", o_last); end
    beat(1'b0);
    checks++; if (o_phase !== 64'h0170_0160_0150_0140) begin errors++; $display("FAIL l3_b1_phase: got %h want 0170016001500140", o_phase); end
    beat(1'b1);
    checks++; if (o_phase !== 64'h01B0_01A0_0190_0180) begin errors++; $display("FAIL l3_b2_phase: got %h want 01b001a001900180", o_phase); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL l3_b2_last: got %0h want 1", o_last); end
    tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL l3_end_ready: got %0h want 0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL l3_end_valid: got %0h want 0", o_valid); end
  endtask

  task automatic test_readback();
`ifdef PG_TABLE_READBACK_EN
    // Readback issued with start: the RD-state read wins, readback is one cycle late.
    i_cfg_ren = 1'b1; i_cfg_raddr = 5'd5;
    i_start = 1'b1; i_entry_sel = 5'd7; i_mode_half = 1'b0;
    tick();
    i_cfg_ren = 1'b0; i_start = 1'b0;
    tick();
    checks++; if (o_cfg_rvalid !== 1'b0) begin errors++; $display("FAIL rb_coll_early: got %0h want 0", o_cfg_rvalid); end
    tick();
    checks++; if (o_cfg_rvalid !== 1'b1) begin errors++; $display("FAIL rb_coll_valid: got %0h want 1", o_cfg_rvalid); end
    checks++; if (o_cfg_rdata !== 32'h0100_0010) begin errors++; $display("FAIL rb_coll_data: got %h want 01000010", o_cfg_rdata); end
    beat(1'b1);
    checks++; if (o_phase !== 64'h0008_0000_FFF8_FFF0) begin errors++; $display("FAIL rb_coll_phase: got %h want 00080000fff8fff0", o_phase); end
    tick();
`else
    i_cfg_ren = 1'b1; i_cfg_raddr = 5'd5;
    tick();
    i_cfg_ren = 1'b0;
    tick();
    checks++; if (o_cfg_rvalid !== 1'b0) begin errors++; $display("FAIL rb_off_valid: got %0h want 0", o_cfg_rvalid); end
    checks++; if (o_cfg_rdata !== 32'h0) begin errors++; $display("FAIL rb_off_data: got %h want 0", o_cfg_rdata); end
`endif
  endtask

  task automatic test_not_full();
    apply_reset();
    load_range(0, 9);
    i_start = 1'b1; i_entry_sel = 5'd0;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL nf_ready: got %0h want 0", o_ready); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL nf_err: got %0h want 1", o_err); end
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL nf_valid_idle: got %0h want 0", o_valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    load_range(0, 31);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ov_err_before: got %0h want 0", o_err); end
    i_cfg_wen = 1'b1; i_cfg_wdata = 32'hDEAD_BEEF;
    tick();
    i_cfg_wen = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ov_err: got %0h want 1", o_err); end
    checks++; if (o_tbl_full !== 1'b1) begin errors++; $display("FAIL ov_full: got %0h want 1", o_tbl_full); end
`ifdef PG_TABLE_READBACK_EN
    i_cfg_ren = 1'b1; i_cfg_raddr = 5'd31;
    tick();
    i_cfg_ren = 1'b0;
    checks++; if (o_cfg_rvalid !== 1'b0) begin errors++; $display("FAIL ov_rb_early: got %0h want 0", o_cfg_rvalid); end
    tick();
    checks++; if (o_cfg_rvalid !== 1'b1) begin errors++; $display("FAIL ov_rb_valid: got %0h want 1", o_cfg_rvalid); end
    checks++; if (o_cfg_rdata !== 32'h101F_0020) begin errors++; $display("FAIL ov_rb_data: got %h want 101f0020", o_cfg_rdata); end
`endif
  endtask

  task automatic test_midframe_reset();
    apply_reset();
    load_range(0, 31);
    start_frame(5'd5, 1'b0);
    i_cfg_wen = 1'b1; i_cfg_wdata = 32'h1234_5678;
    tick();
    i_cfg_wen = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL run_wen_err: got %0h want 1", o_err); end
    beat(1'b0);
    checks++; if (o_phase !== 64'h0130_0120_0110_0100) begin errors++; $display("FAIL mr_b0_phase: got %h want 0130012001100100", o_phase); end
    i_data_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %0h want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mr_ready: got %0h want 0", o_ready); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mr_err: got %0h want 0", o_err); end
    checks++; if (o_tbl_full !== 1'b0) begin errors++; $display("FAIL mr_full: got %0h want 0", o_tbl_full); end
    tick();
    i_data_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_idle_valid: got %0h want 0", o_valid); end
    checks++; if (o_phase !== 64'h0) begin errors++; $display("FAIL mr_idle_phase: got %h want 0", o_phase); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_mode0();
    test_mode1();
    test_wrap();
    test_last3();
    test_readback();
    test_not_full();
    test_overflow();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsp_s2_prep_phase_gen_nlane.md
RSP_S2_PREP_PHASE_GEN_NLANE -- requirements
Module: rsp_s2_prep_phase_gen_nlane

Interface
REQ-001 SHALL have parameter LANES, default 4, output lane count (power of 2, 2..16).
REQ-002 SHALL have parameter PHASE_W, default 16, phase word width.
REQ-003 SHALL have parameter ENTRY_NUM, default 32, entry table depth; ENTRY_AW = $clog2(ENTRY_NUM).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_cfg_wen in 1 (table write strobe), i_cfg_wdata in 2*PHASE_W ({base,step}).
REQ-007 SHALL have ports i_cfg_ren in 1 (readback strobe), i_cfg_raddr in ENTRY_AW, o_cfg_rdata out 2*PHASE_W, o_cfg_rvalid out 1.
REQ-008 SHALL have ports i_start in 1, i_entry_sel in ENTRY_AW, i_mode_half in 1.
REQ-009 SHALL have ports i_data_valid in 1, i_data_last in 1.
REQ-010 SHALL have ports o_phase out LANES*PHASE_W (lane k at bits [k*PHASE_W +: PHASE_W]), o_valid out 1, o_last out 1.
REQ-011 SHALL have ports o_ready out 1 (RUN state), o_tbl_full out 1, o_err out 1 (sticky).

Function
REQ-012 Table write: each i_cfg_wen stores i_cfg_wdata at write pointer, pointer increments; o_tbl_full asserts when pointer reaches ENTRY_NUM, further writes ignored and set o_err.
REQ-013 FSM states IDLE, RD, ARM, RUN; reset state IDLE.
REQ-014 IDLE->RD on i_start while o_tbl_full=1; i_start with o_tbl_full=0 ignored, sets o_err.
REQ-015 RD: table read at captured i_entry_sel, captured i_mode_half; RD->ARM unconditionally.
REQ-016 ARM: lane k phase register = base + k*step; increment INC = step*LANES (mode_half=0) or step*LANES/2 (mode_half=1); ARM->RUN.
REQ-017 All phase arithmetic modulo 2^PHASE_W; carries discarded.
REQ-018 RUN: o_ready=1; on i_data_valid at cycle t, o_phase = lane registers, o_valid=1 at t+1 (latency 1); lane registers += INC.
REQ-019 RUN: cycles without i_data_valid hold lane registers, o_valid=0.
REQ-020 i_data_valid with i_data_last in RUN: o_last=1 with that output beat; FSM RUN->IDLE next cycle.
REQ-021 i_start in RD/ARM/RUN ignored; i_data_valid outside RUN ignored (no o_valid).
REQ-022 i_cfg_wen in any non-IDLE state ignored and sets o_err.
REQ-023 o_err cleared only by rst.

Reset
REQ-024 rst=1 at clock edge: FSM IDLE, write pointer 0, o_tbl_full 0, o_err 0, o_phase 0, o_valid 0, o_last 0, o_ready 0, o_cfg_rvalid 0, o_cfg_rdata 0, lane registers 0.
REQ-025 Reset mid-frame aborts frame; no o_valid on cycle after rst; table contents undefined, reload required.

Configuration
REQ-026 Macro PG_TABLE_READBACK_EN defined: i_cfg_ren reads entry i_cfg_raddr, o_cfg_rdata/o_cfg_rvalid valid 2 cycles later; FSM read in RD has priority, colliding readback delayed one cycle.
REQ-027 Macro absent: i_cfg_ren ignored, o_cfg_rdata and o_cfg_rvalid tied 0, no readback logic.

Verification (LANES=4, PHASE_W=16, ENTRY_NUM=32)
REQ-028 Load 32 entries, entry 5 = {0x0100,0x0010}; start sel 5, mode 0, 2 valids -> beat0 lanes 0x0100,0x0110,0x0120,0x0130; beat1 0x0140,0x0150,0x0160,0x0170.
REQ-029 Same with mode 1 -> beat1 lanes 0x0120,0x0130,0x0140,0x0150.
REQ-030 Entry {0xFFF0,0x0008} -> beat0 0xFFF0,0xFFF8,0x0000,0x0008 (wrap).
REQ-031 Start after only 10 writes -> o_ready stays 0, o_err=1; 33rd write -> o_err=1, entry 31 unchanged (readback with macro).
REQ-032 valid+last on 3rd beat -> o_last=1 on beat 3, o_ready=0 one cycle later; rst mid-frame -> o_valid 0 next cycle, FSM IDLE.
